// File: rtl/coder_pkg.sv
// Shared mode and FSM state encodings for the serial line coders.
package coder_pkg;

  localparam logic [1:0] MODE_MILLER = 2'd0;
  localparam logic [1:0] MODE_FM0    = 2'd1;
  localparam logic [1:0] MODE_MANCH  = 2'd2;
  localparam logic [1:0] MODE_NRZ    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/line_code_step.sv
// Combinational next-level function: the line level for the phase being entered,
// given the current bit, previous bit and present level.
module line_code_step
  import coder_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       b,
  input  logic       p,
  input  logic       level,
  input  logic       is_start,
  input  logic       is_mid,
  output logic       next_level
);

  // Phases that are neither bit start nor mid-bit always hold the level.
  always_comb begin
    next_level = level;
    case (mode)
      MODE_MILLER: begin
        if (is_start && !b && !p) next_level = ~level;
        else if (is_mid && b)     next_level = ~level;
      end
      MODE_FM0: begin
        if (is_start)          next_level = ~level;
        else if (is_mid && !b) next_level = ~level;
      end
      MODE_MANCH: begin
        if (is_start)    next_level = ~b;
        else if (is_mid) next_level = b;
      end
      MODE_NRZ: begin
        if (is_start) next_level = b;
      end
    endcase
  end

endmodule

// File: rtl/miller_line_encoder.sv
// Word-serial line encoder (Miller / FM0 / Manchester / NRZ), MSB first.
// Optional preamble before words accepted from idle: define MILLER_PREAMBLE_EN.
module miller_line_encoder
  import coder_pkg::*;
#(
  parameter int   DATA_W      = 8,
  parameter int   CLK_PER_BIT = 4,
  parameter logic IDLE_LVL    = 1'b0
`ifdef MILLER_PREAMBLE_EN
  ,
  parameter int                    PREAMBLE_W = 4,
  parameter logic [PREAMBLE_W-1:0] PREAMBLE   = 4'b1010
`endif
) (
  input  logic              clk_100m,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        mode_i,
  output logic              code_o,
  output logic              busy_o,
  output logic              bit_strobe_o
);

  localparam int PW = $clog2(CLK_PER_BIT);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [PW-1:0] PH_LAST    = PW'(CLK_PER_BIT - 1);
  localparam logic [PW-1:0] PH_PRE_MID = PW'(CLK_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);

  state_t            state, state_nx;
  logic [PW-1:0]     phase_cnt, phase_nx;
  logic [BW-1:0]     bit_cnt, bit_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic [1:0]        mode_r, mode_nx;
  logic              p, p_nx, code, code_nx;
  logic              ready, accept, bit_end, cur_b;
  logic [1:0]        st_mode;
  logic              st_b, st_p, st_start, st_mid;

`ifdef MILLER_PREAMBLE_EN
  localparam int PCW = (PREAMBLE_W > 1) ? $clog2(PREAMBLE_W) : 1;
  localparam logic [PCW-1:0] PRE_LAST = PCW'(PREAMBLE_W - 1);
  logic [PREAMBLE_W-1:0] pre_shreg, pre_nx;
  logic [PCW-1:0]        pre_cnt, pre_cnt_nx;
`endif

  always_ff @(posedge clk_100m or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Step inputs describe the phase being entered on the next edge.
  always_comb begin
    ready    = (state == ST_IDLE) ||
               (state == ST_DATA && bit_cnt == BIT_LAST && phase_cnt == PH_LAST);
    accept   = valid_i && ready;
    bit_end  = (phase_cnt == PH_LAST);
    cur_b    = shreg[DATA_W-1];
    state_nx = state;
    phase_nx = phase_cnt;
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    mode_nx  = mode_r;
    p_nx     = p;
    st_mode  = mode_r;
    st_b     = cur_b;
    st_p     = p;
    st_start = 1'b0;
    st_mid   = 1'b0;
`ifdef MILLER_PREAMBLE_EN
    pre_nx     = pre_shreg;
    pre_cnt_nx = pre_cnt;
    if (state == ST_PRE) cur_b = pre_shreg[PREAMBLE_W-1];
    st_b = cur_b;
`endif
    if (accept) begin
      state_nx = ST_DATA;
      phase_nx = '0;
      bit_nx   = '0;
      shreg_nx = data_i;
      mode_nx  = mode_i;
      st_mode  = mode_i;
      st_b     = data_i[DATA_W-1];
      st_p     = (state == ST_IDLE || mode_i != mode_r) ? 1'b1 : cur_b;
      p_nx     = st_p;
      st_start = 1'b1;
`ifdef MILLER_PREAMBLE_EN
      if (state == ST_IDLE) begin
        state_nx   = ST_PRE;
        pre_nx     = PREAMBLE;
        pre_cnt_nx = '0;
        st_b       = PREAMBLE[PREAMBLE_W-1];
      end
`endif
    end else if (state != ST_IDLE) begin
      if (!bit_end) begin
        phase_nx = phase_cnt + PW'(1);
        st_mid   = (phase_cnt == PH_PRE_MID);
      end else begin
        phase_nx = '0;
        p_nx     = cur_b;
        st_p     = cur_b;
`ifdef MILLER_PREAMBLE_EN
        if (state == ST_PRE) begin
          st_start = 1'b1;
          if (pre_cnt == PRE_LAST) begin
            state_nx = ST_DATA;
            st_b     = shreg[DATA_W-1];
          end else begin
            pre_cnt_nx = pre_cnt + PCW'(1);
            pre_nx     = pre_shreg << 1;
            st_b       = pre_nx[PREAMBLE_W-1];
          end
        end else
`endif
        if (bit_cnt == BIT_LAST) begin
          state_nx = ST_IDLE;
        end else begin
          bit_nx   = bit_cnt + BW'(1);
          shreg_nx = shreg << 1;
          st_b     = shreg_nx[DATA_W-1];
          st_start = 1'b1;
        end
      end
    end
  end

  line_code_step u_step (
    .mode      (st_mode),
    .b         (st_b),
    .p         (st_p),
    .level     (code),
    .is_start  (st_start),
    .is_mid    (st_mid),
    .next_level(code_nx)
  );

  always_ff @(posedge clk_100m or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      mode_r    <= MODE_MILLER;
      p         <= 1'b1;
      code      <= IDLE_LVL;
`ifdef MILLER_PREAMBLE_EN
      pre_shreg <= '0;
      pre_cnt   <= '0;
`endif
    end else begin
      phase_cnt <= phase_nx;
      bit_cnt   <= bit_nx;
      shreg     <= shreg_nx;
      mode_r    <= mode_nx;
      p         <= p_nx;
      code      <= code_nx;
`ifdef MILLER_PREAMBLE_EN
      pre_shreg <= pre_nx;
      pre_cnt   <= pre_cnt_nx;
`endif
    end
  end

  assign ready_o      = ready;
  assign code_o       = code;
  assign busy_o       = (state != ST_IDLE);
  assign bit_strobe_o = (state != ST_IDLE) && (phase_cnt == '0);

endmodule

// File: tb/tb_miller_line_encoder.sv
// Self-checking bench for miller_line_encoder: table vectors, hand sequences and
// randomized bursts against a half-bit level model.
module tb_miller_line_encoder;

  localparam int   DATA_W   = 8;
  localparam int   CPB      = 4;
  localparam int   T        = DATA_W * CPB;
  localparam logic IDLE_LVL = 1'b0;

  logic              clk_100m = 1'b0;
  logic              rst_n_i  = 1'b0;
  logic [DATA_W-1:0] data_i   = '0;
  logic              valid_i  = 1'b0;
  logic [1:0]        mode_i   = 2'd0;
  logic              ready_o, code_o, busy_o, bit_strobe_o;

  int   checks = 0;
  int   errors = 0;
  logic ml, mp;
  logic exp_q[$];
  logic [DATA_W-1:0] bw_data[4];
  logic [1:0]        bw_mode[4];

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  mode;
    logic [15:0] halves;
  } vec_t;
  vec_t vecs[7];

  miller_line_encoder #(
    .DATA_W     (DATA_W),
    .CLK_PER_BIT(CPB),
    .IDLE_LVL   (IDLE_LVL)
  ) dut (
    .clk_100m    (clk_100m),
    .rst_n_i     (rst_n_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .mode_i      (mode_i),
    .code_o      (code_o),
    .busy_o      (busy_o),
    .bit_strobe_o(bit_strobe_o)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0b expected %0b", name, actual, expected);
    end
  endtask

  // Reference model: first/second half level of each bit, expanded to clocks.
  task automatic modelWord(input logic [DATA_W-1:0] d, input logic [1:0] m);
    logic b, h1, h2;
    exp_q.delete();
    for (int i = DATA_W - 1; i >= 0; i--) begin
      b = d[i];
      case (m)
        2'd0:    begin h1 = (!b && !mp) ? ~ml : ml; h2 = b ? ~h1 : h1; end
        2'd1:    begin h1 = ~ml; h2 = b ? h1 : ~h1; end
        2'd2:    begin h1 = ~b; h2 = b; end
        default: begin h1 = b; h2 = b; end
      endcase
      repeat (CPB / 2) exp_q.push_back(h1);
      repeat (CPB / 2) exp_q.push_back(h2);
      ml = h2;
      mp = b;
    end
  endtask

  task automatic doReset();
    @(negedge clk_100m);
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    repeat (2) @(negedge clk_100m);
    checkOutput("rst_code", code_o, IDLE_LVL);
    checkOutput("rst_ready", ready_o, 1'b1);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_strobe", bit_strobe_o, 1'b0);
    rst_n_i = 1'b1;
    ml = IDLE_LVL;
    mp = 1'b1;
  endtask

  // Sends bw_data/bw_mode[0..n-1] back to back; junk valid while not ready.
  task automatic applyStimulus(input int n, input logic use_tab, input logic [15:0] tab);
    logic [1:0] prev_mode;
    logic       e;
    @(negedge clk_100m);
    checkOutput("idle_ready", ready_o, 1'b1);
    checkOutput("idle_busy", busy_o, 1'b0);
    data_i  = bw_data[0];
    mode_i  = bw_mode[0];
    valid_i = 1'b1;
    for (int w = 0; w < n; w++) begin
      if (w == 0 || bw_mode[w] != prev_mode) mp = 1'b1;
      prev_mode = bw_mode[w];
      modelWord(bw_data[w], bw_mode[w]);
      for (int k = 0; k < T; k++) begin
        @(negedge clk_100m);
        e = use_tab ? tab[15 - k / (CPB / 2)] : exp_q[k];
        checkOutput($sformatf("code w%0d k%0d", w, k), code_o, e);
        checkOutput($sformatf("busy w%0d k%0d", w, k), busy_o, 1'b1);
        checkOutput($sformatf("strobe w%0d k%0d", w, k), bit_strobe_o, (k % CPB) == 0);
        checkOutput($sformatf("ready w%0d k%0d", w, k), ready_o, k == T - 1);
        if (k == T - 1) begin
          valid_i = (w < n - 1);
          if (w < n - 1) begin
            data_i = bw_data[w+1];
            mode_i = bw_mode[w+1];
          end
        end else begin
          valid_i = 1'($urandom_range(0, 1));
          data_i  = DATA_W'($urandom);
          mode_i  = 2'($urandom);
        end
      end
    end
    @(negedge clk_100m);
    checkOutput("end_busy", busy_o, 1'b0);
    checkOutput("end_ready", ready_o, 1'b1);
    checkOutput("end_strobe", bit_strobe_o, 1'b0);
    checkOutput("end_code_hold", code_o, ml);
    valid_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h12, 2'd0, 16'h31C7};
    vecs[1] = '{8'h00, 2'd0, 16'h3333};
    vecs[2] = '{8'hFF, 2'd0, 16'h6666};
    vecs[3] = '{8'hFF, 2'd1, 16'hCCCC};
    vecs[4] = '{8'h00, 2'd1, 16'hAAAA};
    vecs[5] = '{8'hA5, 2'd2, 16'h6699};
    vecs[6] = '{8'hA5, 2'd3, 16'hCC33};

    doReset();
    for (int v = 0; v < 7; v++) begin
      doReset();
      bw_data[0] = vecs[v].data;
      bw_mode[0] = vecs[v].mode;
      applyStimulus(1, 1'b1, vecs[v].halves);
    end

    $display("[TB] back-to-back Miller words");
    doReset();
    bw_data[0] = 8'h00; bw_mode[0] = 2'd0;
    bw_data[1] = 8'h00; bw_mode[1] = 2'd0;
    applyStimulus(2, 1'b0, 16'h0);

    $display("[TB] back-to-back with mode changes");
    bw_data[0] = 8'h12; bw_mode[0] = 2'd0;
    bw_data[1] = 8'h3C; bw_mode[1] = 2'd2;
    bw_data[2] = 8'h00; bw_mode[2] = 2'd0;
    bw_data[3] = 8'h81; bw_mode[3] = 2'd3;
    applyStimulus(4, 1'b0, 16'h0);

    $display("[TB] reset in the middle of a word");
    doReset();
    modelWord(8'h00, 2'd0);
    @(negedge clk_100m);
    data_i  = 8'h00;
    mode_i  = 2'd0;
    valid_i = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk_100m);
      valid_i = 1'b0;
    end
    checkOutput("pre_reset_code", code_o, exp_q[13]);
    #2 rst_n_i = 1'b0;
    #1;
    checkOutput("async_rst_code", code_o, IDLE_LVL);
    checkOutput("async_rst_ready", ready_o, 1'b1);
    checkOutput("async_rst_busy", busy_o, 1'b0);
    checkOutput("async_rst_strobe", bit_strobe_o, 1'b0);
    @(negedge clk_100m);
    rst_n_i = 1'b1;
    ml = IDLE_LVL;
    mp = 1'b1;
    bw_data[0] = 8'h12; bw_mode[0] = 2'd0;
    applyStimulus(1, 1'b1, 16'h31C7);

    $display("[TB] randomized bursts");
    for (int r = 0; r < 20; r++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        bw_data[i] = DATA_W'($urandom);
        bw_mode[i] = 2'($urandom);
      end
      applyStimulus(n, 1'b0, 16'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
